mcycle_issue_scheduler: RTL

- Arbitrates one instruction issue per cycle among hardware threads that target either the single-cycle pipeline or the multi-cycle FP pipeline (mx1..mxN).
- Reserves writeback slots so a multi-cycle result and a single-cycle result never reach writeback in the same cycle.
- Tracks outstanding multi-cycle operations per thread, squashing them on rollback, so thread select can hold dependent issues.
- Sits between thread select and operand fetch.

---
 rtl/mcycle_issue_scheduler_if.sv | 32 +++
 rtl/mcycle_issue_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mcycle_issue_scheduler_if.sv
// Issue-scheduler bus between thread select, the scheduler and writeback.
// The master side drives requests and rollbacks; the slave side (the
// scheduler) returns grants, pending flags and the multi-cycle writeback.
interface mcycle_issue_scheduler_if #(
  parameter int THREADS = 4
);
  localparam int TW = $clog2(THREADS);

  logic [THREADS-1:0] ts_request;
  logic [THREADS-1:0] ts_is_mcycle;
  logic [THREADS-1:0] ts_grant;
  logic               sched_issue_valid;
  logic [TW-1:0]      sched_issue_thread;
  logic               sched_issue_mcycle;
  logic               wb_rollback_en;
  logic [TW-1:0]      wb_rollback_thread_idx;
  logic [THREADS-1:0] mc_pending;
  logic               mc_wb_valid;
  logic [TW-1:0]      mc_wb_thread;

  modport master (
    output ts_request, ts_is_mcycle, wb_rollback_en, wb_rollback_thread_idx,
    input  ts_grant, sched_issue_valid, sched_issue_thread, sched_issue_mcycle,
    input  mc_pending, mc_wb_valid, mc_wb_thread
  );

  modport slave (
    input  ts_request, ts_is_mcycle, wb_rollback_en, wb_rollback_thread_idx,
    output ts_grant, sched_issue_valid, sched_issue_thread, sched_issue_mcycle,
    output mc_pending, mc_wb_valid, mc_wb_thread
  );
endinterface

// File: rtl/mcycle_issue_scheduler.sv
// Round-robin issue scheduler for single-cycle and multi-cycle FP ops.
// A shifting slot array reserves future writeback cycles so single-cycle
// and multi-cycle results never collide; per-thread counters track live
// multi-cycle work and are cleared by rollback.
module mcycle_issue_scheduler #(
  parameter int THREADS    = 4,
  parameter int MC_LATENCY = 5,
  parameter int SC_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  mcycle_issue_scheduler_if.slave bus
);
  localparam int TW = $clog2(THREADS);

  // Entry k describes the writeback cycle k cycles from now.
  typedef struct packed {
    logic          reserved;
    logic          live;
    logic [TW-1:0] thread;
  } slot_t;

  slot_t [MC_LATENCY-1:0]   slot_q, slot_d;
  logic  [THREADS-1:0][2:0] cnt_q, cnt_d;
  logic  [TW-1:0]           rr_q, rr_d;

  logic [THREADS-1:0] elig;
  logic [THREADS-1:0] grant;
  logic               gnt_vld;
  logic [TW-1:0]      gnt_idx;
  logic               gnt_mc;
  logic [TW-1:0]      scan_idx;
  logic               wb_vld;

  assign wb_vld = slot_q[0].reserved && slot_q[0].live;

  // Eligibility: requesting, not being rolled back, and the target resource free.
  // Gated by reset so every output is quiet while reset is held.
  always_comb begin
    elig = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (!reset && bus.ts_request[t] &&
          !(bus.wb_rollback_en && (bus.wb_rollback_thread_idx == TW'(t)))) begin
        if (bus.ts_is_mcycle[t]) elig[t] = (cnt_q[t] != 3'd7);
        else                     elig[t] = !slot_q[SC_LATENCY].reserved;
      end
    end
  end

  // Round-robin pick: first eligible thread at or after rr_q wins.
  always_comb begin
    grant    = '0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < THREADS; i++) begin
      scan_idx = rr_q + TW'(i);
      if (!gnt_vld && elig[scan_idx]) begin
        gnt_vld         = 1'b1;
        gnt_idx         = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
    gnt_mc = gnt_vld && bus.ts_is_mcycle[gnt_idx];
  end

  // Slot shift, rollback squash, new reservation and pointer advance.
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < MC_LATENCY - 1; k++) slot_d[k] = slot_q[k+1];
    if (bus.wb_rollback_en) begin
      for (int k = 0; k < MC_LATENCY; k++) begin
        if (slot_d[k].live && (slot_d[k].thread == bus.wb_rollback_thread_idx))
          slot_d[k].live = 1'b0;
      end
    end
    if (gnt_vld) begin
      if (gnt_mc) slot_d[MC_LATENCY-1] = {1'b1, 1'b1, gnt_idx};
      else        slot_d[SC_LATENCY-1] = {1'b1, 1'b0, gnt_idx};
    end
    rr_d = gnt_vld ? gnt_idx + TW'(1) : rr_q;
  end

  // Pending counters: rollback clears, otherwise net of grant and writeback.
  always_comb begin
    logic inc;
    logic dec;
    inc   = 1'b0;
    dec   = 1'b0;
    cnt_d = cnt_q;
    for (int t = 0; t < THREADS; t++) begin
      inc = gnt_mc && (gnt_idx == TW'(t));
      dec = wb_vld && (slot_q[0].thread == TW'(t));
      if (bus.wb_rollback_en && (bus.wb_rollback_thread_idx == TW'(t)))
        cnt_d[t] = 3'd0;
      else if (inc && !dec)
        cnt_d[t] = cnt_q[t] + 3'd1;
      else if (dec && !inc)
        cnt_d[t] = cnt_q[t] - 3'd1;
    end
  end

  // State registers; reset drops all in-flight reservations immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  // Pending flags per thread.
  always_comb begin
    bus.mc_pending = '0;
    for (int t = 0; t < THREADS; t++) bus.mc_pending[t] = (cnt_q[t] != 3'd0);
  end

  assign bus.ts_grant           = grant;
  assign bus.sched_issue_valid  = gnt_vld;
  assign bus.sched_issue_thread = gnt_idx;
  assign bus.sched_issue_mcycle = gnt_mc;
  assign bus.mc_wb_valid        = wb_vld;
  assign bus.mc_wb_thread       = slot_q[0].thread;
endmodule
